sim_jtag_tap: RTL and testbench

Testbench-side JTAG TAP responder: the target end of the simulated JTAG link. It oversamples jtag_TCK/TMS/TDI/TRSTn, driven by the DPI JTAG driver, on the system clock. It runs the IEEE 1149.1 16-state TAP controller with a RISC-V debug-transport register set (IDCODE, DTMCS, DMI, BYPASS) and returns TDO plus a TDO-driven qualifier. DMI accesses are forwarded to a debug-module-side valid/ready request port, and responses are collected for the next capture.

---
 rtl/sim_jtag_tap.sv | 203 ++++++++++++++++++++
 tb/tb_sim_jtag_tap.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_jtag_tap.sv
// Simulation-side JTAG TAP responder with the RISC-V debug transport registers.
// JTAG pins are oversampled on clock; DMI updates become valid/ready requests toward the debug module.
module sim_jtag_tap #(
  parameter logic [31:0] IDCODE = 32'h1000_0DB3,
  parameter int unsigned ABITS  = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             jtag_TCK,
  input  logic             jtag_TMS,
  input  logic             jtag_TDI,
  input  logic             jtag_TRSTn,
  output logic             jtag_TDO_data,
  output logic             jtag_TDO_driven,
  output logic             dmi_req_valid,
  input  logic             dmi_req_ready,
  output logic [ABITS-1:0] dmi_req_addr,
  output logic [31:0]      dmi_req_data,
  output logic [1:0]       dmi_req_op,
  input  logic             dmi_rsp_valid,
  input  logic [31:0]      dmi_rsp_data
);

  localparam int unsigned DMI_W     = ABITS + 34;
  localparam logic [4:0]  IR_IDCODE = 5'h01;
  localparam logic [4:0]  IR_DTMCS  = 5'h10;
  localparam logic [4:0]  IR_DMI    = 5'h11;
  localparam logic [5:0]  ABITS_F   = 6'(ABITS);

  typedef enum logic [3:0] {
    TLR      = 4'd0,  RTI      = 4'd1,  SEL_DR   = 4'd2,  CAP_DR   = 4'd3,
    SHIFT_DR = 4'd4,  EXIT1_DR = 4'd5,  PAUSE_DR = 4'd6,  EXIT2_DR = 4'd7,
    UPD_DR   = 4'd8,  SEL_IR   = 4'd9,  CAP_IR   = 4'd10, SHIFT_IR = 4'd11,
    EXIT1_IR = 4'd12, PAUSE_IR = 4'd13, EXIT2_IR = 4'd14, UPD_IR   = 4'd15
  } tap_state_t;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    case (s)
      TLR:      return tms ? TLR      : RTI;
      RTI:      return tms ? SEL_DR   : RTI;
      SEL_DR:   return tms ? SEL_IR   : CAP_DR;
      CAP_DR:   return tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: return tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: return tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: return tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: return tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   return tms ? SEL_DR   : RTI;
      SEL_IR:   return tms ? TLR      : CAP_IR;
      CAP_IR:   return tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: return tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: return tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: return tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: return tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   return tms ? SEL_DR   : RTI;
      default:  return TLR;
    endcase
  endfunction

  logic [1:0]       tck_sync_r, tms_sync_r, tdi_sync_r, trstn_sync_r;
  logic             tck_d_r;
  logic             rise_s, fall_s, trst_s, tms_s, tdi_s;
  tap_state_t       state_r;
  logic [4:0]       ir_r, ir_shift_r;
  logic [31:0]      dr32_shift_r;
  logic [DMI_W-1:0] dmi_shift_r;
  logic             bypass_r;
  logic             busy_r, outstanding_r;
  logic [31:0]      rsp_data_r;
  logic [ABITS-1:0] last_addr_r;
  logic [1:0]       dmistat_s, dmi_status_s;
  logic [31:0]      dtmcs_capture_s;
  logic [DMI_W-1:0] dmi_capture_s;
  logic             tdo_bit_s, in_shift_s;

  assign rise_s = tck_sync_r[1] & ~tck_d_r;
  assign fall_s = ~tck_sync_r[1] & tck_d_r;
  assign trst_s = ~trstn_sync_r[1];
  assign tms_s  = tms_sync_r[1];
  assign tdi_s  = tdi_sync_r[1];

  assign dmistat_s       = busy_r ? 2'd3 : 2'd0;
  assign dmi_status_s    = (busy_r || outstanding_r) ? 2'd3 : 2'd0;
  assign dtmcs_capture_s = {14'd0, 1'b0, 1'b0, 1'b0, 3'd1, dmistat_s, ABITS_F, 4'd1};
  assign dmi_capture_s   = {last_addr_r, rsp_data_r, dmi_status_s};
  assign in_shift_s      = (state_r == SHIFT_IR) || (state_r == SHIFT_DR);

  // Pin synchronizers plus a delayed TCK copy for edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      tck_sync_r   <= 2'b00;
      tck_d_r      <= 1'b0;
      tms_sync_r   <= 2'b00;
      tdi_sync_r   <= 2'b00;
      trstn_sync_r <= 2'b11;
    end else begin
      tck_sync_r   <= {tck_sync_r[0], jtag_TCK};
      tck_d_r      <= tck_sync_r[1];
      tms_sync_r   <= {tms_sync_r[0], jtag_TMS};
      tdi_sync_r   <= {tdi_sync_r[0], jtag_TDI};
      trstn_sync_r <= {trstn_sync_r[0], jtag_TRSTn};
    end
  end

  // Bit presented on TDO at the next falling edge
  always_comb begin
    tdo_bit_s = 1'b0;
    if (state_r == SHIFT_IR) begin
      tdo_bit_s = ir_shift_r[0];
    end else if (state_r == SHIFT_DR) begin
      case (ir_r)
        IR_IDCODE, IR_DTMCS: tdo_bit_s = dr32_shift_r[0];
        IR_DMI:              tdo_bit_s = dmi_shift_r[0];
        default:             tdo_bit_s = bypass_r;
      endcase
    end else begin
      tdo_bit_s = 1'b0;
    end
  end

  // TAP controller, scan registers and DMI request/response tracking
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r         <= TLR;
      ir_r            <= IR_IDCODE;
      ir_shift_r      <= 5'd0;
      dr32_shift_r    <= 32'd0;
      dmi_shift_r     <= '0;
      bypass_r        <= 1'b0;
      jtag_TDO_data   <= 1'b0;
      jtag_TDO_driven <= 1'b0;
      dmi_req_valid   <= 1'b0;
      dmi_req_addr    <= '0;
      dmi_req_data    <= 32'd0;
      dmi_req_op      <= 2'd0;
      rsp_data_r      <= 32'd0;
      busy_r          <= 1'b0;
      outstanding_r   <= 1'b0;
      last_addr_r     <= '0;
    end else begin
      if (dmi_req_valid && dmi_req_ready) dmi_req_valid <= 1'b0;
      if (dmi_rsp_valid && outstanding_r) begin
        rsp_data_r    <= dmi_rsp_data;
        outstanding_r <= 1'b0;
      end
      if (trst_s) begin
        state_r <= TLR;
        ir_r    <= IR_IDCODE;
      end else begin
        if (state_r == TLR) ir_r <= IR_IDCODE;
        if (rise_s) begin
          case (state_r)
            CAP_IR:   ir_shift_r <= 5'b00001;
            SHIFT_IR: ir_shift_r <= {tdi_s, ir_shift_r[4:1]};
            CAP_DR: begin
              case (ir_r)
                IR_IDCODE: dr32_shift_r <= IDCODE;
                IR_DTMCS:  dr32_shift_r <= dtmcs_capture_s;
                IR_DMI:    dmi_shift_r  <= dmi_capture_s;
                default:   bypass_r     <= 1'b0;
              endcase
            end
            SHIFT_DR: begin
              case (ir_r)
                IR_IDCODE, IR_DTMCS: dr32_shift_r <= {tdi_s, dr32_shift_r[31:1]};
                IR_DMI:              dmi_shift_r  <= {tdi_s, dmi_shift_r[DMI_W-1:1]};
                default:             bypass_r     <= tdi_s;
              endcase
            end
            default: ;
          endcase
          state_r <= tap_next(state_r, tms_s);
        end else if (fall_s) begin
          jtag_TDO_driven <= in_shift_s;
          jtag_TDO_data   <= tdo_bit_s;
          if (state_r == UPD_IR) begin
            ir_r <= ir_shift_r;
          end else if (state_r == UPD_DR && ir_r == IR_DTMCS) begin
            // Hard reset abandons the in-flight request; a later response is then ignored
            if (dr32_shift_r[17]) begin
              dmi_req_valid <= 1'b0;
              outstanding_r <= 1'b0;
              busy_r        <= 1'b0;
            end else if (dr32_shift_r[16]) begin
              busy_r <= 1'b0;
            end
          end else if (state_r == UPD_DR && ir_r == IR_DMI) begin
            if (outstanding_r) begin
              busy_r <= 1'b1;
            end else if (dmi_shift_r[1:0] == 2'd1 || dmi_shift_r[1:0] == 2'd2) begin
              dmi_req_addr  <= dmi_shift_r[DMI_W-1:34];
              dmi_req_data  <= dmi_shift_r[33:2];
              dmi_req_op    <= dmi_shift_r[1:0];
              dmi_req_valid <= 1'b1;
              outstanding_r <= 1'b1;
              last_addr_r   <= dmi_shift_r[DMI_W-1:34];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sim_jtag_tap.sv
// Randomized bench for sim_jtag_tap: drives the JTAG pins bit by bit and predicts each
// captured register and DMI request from a register-level model of the debug transport.
module tb_sim_jtag_tap;
  localparam int          ABITS    = 7;
  localparam int          PH       = 5;
  localparam logic [31:0] IDCODE_V = 32'h1000_0DB3;

  logic             clock, reset;
  logic             jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
  logic             jtag_TDO_data, jtag_TDO_driven;
  logic             dmi_req_valid, dmi_req_ready;
  logic [ABITS-1:0] dmi_req_addr;
  logic [31:0]      dmi_req_data;
  logic [1:0]       dmi_req_op;
  logic             dmi_rsp_valid;
  logic [31:0]      dmi_rsp_data;

  sim_jtag_tap dut (
    .clock(clock), .reset(reset),
    .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TRSTn(jtag_TRSTn),
    .jtag_TDO_data(jtag_TDO_data), .jtag_TDO_driven(jtag_TDO_driven),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
    .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_data(dmi_rsp_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Register-level model of the debug transport
  logic [4:0]       m_ir;
  logic             m_busy, m_out, m_req;
  logic [31:0]      m_rsp, m_req_data;
  logic [ABITS-1:0] m_last, m_req_addr;
  logic [1:0]       m_req_op;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int dr_len(input logic [4:0] ir);
    case (ir)
      5'h01, 5'h10: return 32;
      5'h11:        return ABITS + 34;
      default:      return 1;
    endcase
  endfunction

  function automatic logic [63:0] exp_capture();
    case (m_ir)
      5'h01:   return 64'(IDCODE_V);
      5'h10:   return 64'(32'd1 + (32'(ABITS) << 4) + (32'd1 << 12) + (m_busy ? (32'd3 << 10) : 32'd0));
      5'h11:   return (64'(m_last) << 34) + (64'(m_rsp) << 2) + ((m_busy || m_out) ? 64'd3 : 64'd0);
      default: return 64'd0;
    endcase
  endfunction

  task automatic model_dr_update(input logic [63:0] din);
    case (m_ir)
      5'h10: begin
        if (din[17]) begin
          m_busy = 1'b0; m_out = 1'b0; m_req = 1'b0;
        end else if (din[16]) begin
          m_busy = 1'b0;
        end
      end
      5'h11: begin
        if (m_out) begin
          m_busy = 1'b1;
        end else if (din[1:0] == 2'd1 || din[1:0] == 2'd2) begin
          m_out = 1'b1; m_req = 1'b1;
          m_req_addr = din[ABITS+33:34]; m_req_data = din[33:2]; m_req_op = din[1:0];
          m_last = din[ABITS+33:34];
        end
      end
      default: ;
    endcase
  endtask

  // One TCK period: returns TDO/driven as they stood before this rise
  task automatic jtag_clk(input logic tms, input logic tdi, output logic tdo, output logic drv);
    @(negedge clock);
    tdo = jtag_TDO_data;
    drv = jtag_TDO_driven;
    jtag_TMS = tms;
    jtag_TDI = tdi;
    repeat (PH) @(negedge clock);
    jtag_TCK = 1'b1;
    repeat (PH) @(negedge clock);
    jtag_TCK = 1'b0;
    repeat (PH) @(negedge clock);
  endtask

  task automatic goto_rti();
    logic tdo, drv;
    for (int i = 0; i < 5; i++) jtag_clk(1'b1, 1'b0, tdo, drv);
    jtag_clk(1'b0, 1'b0, tdo, drv);
    m_ir = 5'h01;
  endtask

  task automatic shift_ir(input string tag, input logic [4:0] v);
    logic tdo, drv;
    logic [4:0] dout;
    jtag_clk(1'b1, 1'b0, tdo, drv);
    jtag_clk(1'b1, 1'b0, tdo, drv);
    jtag_clk(1'b0, 1'b0, tdo, drv);
    jtag_clk(1'b0, 1'b0, tdo, drv);
    for (int i = 0; i < 5; i++) begin
      jtag_clk(i == 4, v[i], tdo, drv);
      dout[i] = tdo;
    end
    jtag_clk(1'b1, 1'b0, tdo, drv);
    jtag_clk(1'b0, 1'b0, tdo, drv);
    check_eq({tag, "_ircap"}, 64'(dout), 64'd1);
    m_ir = v;
  endtask

  // RTI -> Shift-DR, shift n bits, Update-DR -> RTI, checking TDO against the model
  task automatic shift_dr_chk(input string tag, input logic [63:0] din, input int n);
    logic tdo, drv, drv_ok;
    logic [63:0] cap, expv, dout;
    int len;
    len  = dr_len(m_ir);
    cap  = exp_capture();
    expv = 64'd0;
    for (int i = 0; i < n; i++) begin
      if (i < len) expv[i] = cap[i];
      else         expv[i] = din[i-len];
    end
    jtag_clk(1'b1, 1'b0, tdo, drv);
    jtag_clk(1'b0, 1'b0, tdo, drv);
    jtag_clk(1'b0, 1'b0, tdo, drv);
    check_eq({tag, "_drv_pre"}, 64'(drv), 64'd0);
    dout   = 64'd0;
    drv_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      jtag_clk(i == n - 1, din[i], tdo, drv);
      dout[i] = tdo;
      if (drv !== 1'b1) drv_ok = 1'b0;
    end
    check_eq({tag, "_tdo"}, dout, expv);
    check_eq({tag, "_drv_shift"}, 64'(drv_ok), 64'd1);
    jtag_clk(1'b1, 1'b0, tdo, drv);
    check_eq({tag, "_drv_exit"}, 64'(drv), 64'd0);
    jtag_clk(1'b0, 1'b0, tdo, drv);
    model_dr_update(din);
    check_eq({tag, "_reqv"}, 64'(dmi_req_valid), 64'(m_req));
  endtask

  task automatic rsp_pulse(input logic [31:0] d);
    @(negedge clock);
    dmi_rsp_data  = d;
    dmi_rsp_valid = 1'b1;
    @(negedge clock);
    dmi_rsp_valid = 1'b0;
    if (m_out) begin
      m_rsp = d;
      m_out = 1'b0;
    end
  endtask

  task automatic serve_req(input string tag, input int delay, input bit respond, input logic [31:0] d);
    int waited = 0;
    while (!dmi_req_valid && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    check_eq({tag, "_valid"}, 64'(dmi_req_valid), 64'(m_req));
    check_eq({tag, "_fields"}, 64'({dmi_req_addr, dmi_req_data, dmi_req_op}),
             64'({m_req_addr, m_req_data, m_req_op}));
    repeat (delay) @(negedge clock);
    dmi_req_ready = 1'b1;
    @(negedge clock);
    dmi_req_ready = 1'b0;
    m_req = 1'b0;
    check_eq({tag, "_drop"}, 64'(dmi_req_valid), 64'd0);
    if (respond) rsp_pulse(d);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic tdo, drv, hold_ok;
    logic [4:0]  irsel;
    logic [63:0] din;
    logic [ABITS-1:0] hr_addr;
    reset = 1'b1; jtag_TCK = 1'b0; jtag_TMS = 1'b0; jtag_TDI = 1'b0; jtag_TRSTn = 1'b1;
    dmi_req_ready = 1'b0; dmi_rsp_valid = 1'b0; dmi_rsp_data = 32'd0;
    m_ir = 5'h01; m_busy = 1'b0; m_out = 1'b0; m_req = 1'b0; m_rsp = 32'd0;
    m_last = '0; m_req_addr = '0; m_req_data = 32'd0; m_req_op = 2'd0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_tdo", 64'({jtag_TDO_driven, jtag_TDO_data}), 64'd0);
    check_eq("rst_req", 64'({dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op}), 64'd0);

    // IDCODE selected by default after reset
    goto_rti();
    shift_dr_chk("idcode", 64'($urandom), 32);
    shift_dr_chk("idcode2", 64'($urandom), 32);

    // BYPASS: all-ones IR and a few random unassigned codes
    shift_ir("ir1f", 5'h1F);
    shift_dr_chk("bypass_pat", 64'b1101, 4);
    for (int k = 0; k < 2; k++) begin
      do irsel = 5'($urandom); while (irsel == 5'h01 || irsel == 5'h10 || irsel == 5'h11);
      shift_ir("irbyp", irsel);
      shift_dr_chk("bypass_rnd", {$urandom, $urandom}, 10);
    end

    shift_ir("irdtm", 5'h10);
    shift_dr_chk("dtmcs", 64'd0, 32);

    // DMI write held off by ready for five cycles
    shift_ir("irdmi", 5'h11);
    shift_dr_chk("dmi_wr", 64'({7'h10, 32'hCAFE_F00D, 2'd2}), ABITS + 34);
    hold_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (!dmi_req_valid || {dmi_req_addr, dmi_req_data, dmi_req_op} !== {7'h10, 32'hCAFE_F00D, 2'd2})
        hold_ok = 1'b0;
      @(negedge clock);
    end
    check_eq("wr_hold", 64'(hold_ok), 64'd1);
    dmi_req_ready = 1'b1;
    @(negedge clock);
    dmi_req_ready = 1'b0;
    m_req = 1'b0;
    check_eq("wr_drop", 64'(dmi_req_valid), 64'd0);
    rsp_pulse($urandom);
    shift_dr_chk("dmi_after_wr", 64'd0, ABITS + 34);

    // DMI read, then a second update before the response arrives
    shift_dr_chk("dmi_rd", 64'({7'h11, $urandom, 2'd1}), ABITS + 34);
    serve_req("rd", 0, 1'b0, 32'd0);
    shift_dr_chk("dmi_busy", 64'({7'h11, $urandom, 2'd1}), ABITS + 34);
    shift_ir("irdtm2", 5'h10);
    shift_dr_chk("dtmcs_busy", 64'd0, 32);
    rsp_pulse(32'h1234_5678);
    shift_dr_chk("dtmcs_clr", 64'd1 << 16, 32);
    shift_dr_chk("dtmcs_idle", 64'd0, 32);
    shift_ir("irdmi2", 5'h11);
    shift_dr_chk("dmi_rd_rsp", 64'd0, ABITS + 34);

    // dmihardreset drops a pending request; a stray response afterwards is ignored
    hr_addr = 7'($urandom);
    shift_dr_chk("dmi_hr_req", 64'({hr_addr, $urandom, 2'd2}), ABITS + 34);
    shift_ir("irdtm3", 5'h10);
    shift_dr_chk("dtmcs_hard", 64'd1 << 17, 32);
    rsp_pulse($urandom);
    shift_ir("irdmi3", 5'h11);
    shift_dr_chk("dmi_after_hr", 64'd0, ABITS + 34);

    // TRSTn mid-Shift-DR with a request pending
    shift_dr_chk("trst_req", 64'({7'($urandom), $urandom, 2'd2}), ABITS + 34);
    jtag_clk(1'b1, 1'b0, tdo, drv);
    jtag_clk(1'b0, 1'b0, tdo, drv);
    jtag_clk(1'b0, 1'b0, tdo, drv);
    for (int k = 0; k < 3; k++) jtag_clk(1'b0, 1'($urandom), tdo, drv);
    check_eq("trst_in_shift", 64'(jtag_TDO_driven), 64'd1);
    jtag_TRSTn = 1'b0;
    repeat (8) @(negedge clock);
    jtag_TRSTn = 1'b1;
    repeat (8) @(negedge clock);
    check_eq("trst_req_kept", 64'({dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op}),
             64'({m_req, m_req_addr, m_req_data, m_req_op}));
    jtag_clk(1'b1, 1'b0, tdo, drv);
    check_eq("trst_tdo", 64'({jtag_TDO_driven, jtag_TDO_data}), 64'd0);
    m_ir = 5'h01;
    jtag_clk(1'b0, 1'b0, tdo, drv);
    shift_dr_chk("trst_idcode", 64'($urandom), 32);
    serve_req("trst_srv", 1, 1'b1, $urandom);

    // Random register traffic against the model
    for (int it = 0; it < 6; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          shift_ir("r_ir", 5'h01);
          shift_dr_chk("r_idcode", 64'($urandom), 32);
        end
        1: begin
          shift_ir("r_ir", 5'h10);
          shift_dr_chk("r_dtmcs", 64'($urandom), 32);
        end
        2: begin
          shift_ir("r_ir", 5'h11);
          shift_dr_chk("r_dmi", 64'({7'($urandom), $urandom, 2'($urandom)}), ABITS + 34);
        end
        default: begin
          do irsel = 5'($urandom); while (irsel == 5'h01 || irsel == 5'h10 || irsel == 5'h11);
          shift_ir("r_ir", irsel);
          shift_dr_chk("r_bypass", {$urandom, $urandom}, $urandom_range(1, 12));
        end
      endcase
      if (m_req) serve_req("r_srv", $urandom_range(0, 3), 1'($urandom), $urandom);
    end
    shift_ir("r_irend", 5'h11);
    shift_dr_chk("r_dmi_end", 64'd0, ABITS + 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
